// File: rtl/loopback_fifo_if.sv
// Byte-stream handshake bundle between usb_dfu and the loopback FIFO.
// The slave modport is the FIFO side, the master modport is the usb_dfu side.
interface loopback_fifo_if;
   logic [7:0] out_data_i;
   logic       out_valid_i;
   logic       out_ready_o;
   logic [7:0] in_data_o;
   logic       in_valid_o;
   logic       in_ready_i;

   modport master (
      output out_data_i,
      output out_valid_i,
      output in_ready_i,
      input  out_ready_o,
      input  in_data_o,
      input  in_valid_o
   );

   modport slave (
      input  out_data_i,
      input  out_valid_i,
      input  in_ready_i,
      output out_ready_o,
      output in_data_o,
      output in_valid_o
   );
endinterface

// File: rtl/loopback_fifo.sv
// First-word fall-through byte FIFO returning the OUT stream on the IN port,
// with fill level, accepted-byte counter and a stretched activity flag.
module loopback_fifo #(
   parameter int DEPTH    = 64,
   parameter int ACT_BITS = 16
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic                       clear_i,
   loopback_fifo_if.slave             bus,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic [15:0]                rx_count_o,
   output logic                       activity_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [7:0]          mem_q [DEPTH];
   logic [AW-1:0]       wp_q, wp_d;
   logic [AW-1:0]       rp_q, rp_d;
   logic [AW:0]         level_q, level_d;
   logic [15:0]         rx_q, rx_d;
   logic [ACT_BITS-1:0] act_q, act_d;
   logic                push, pop;

   assign bus.out_ready_o = (level_q != FULL);
   assign bus.in_valid_o  = (level_q != '0);
   assign bus.in_data_o   = mem_q[rp_q];
   assign level_o         = level_q;
   assign rx_count_o      = rx_q;
   assign activity_o      = (act_q != '0);

   assign push = bus.out_valid_i & bus.out_ready_o;
   assign pop  = bus.in_valid_o & bus.in_ready_i;

   always_comb begin
      wp_d    = wp_q;
      rp_d    = rp_q;
      level_d = level_q;
      rx_d    = rx_q;
      act_d   = act_q;
      if (push) rx_d = rx_q + 16'd1;
      if (push || pop) act_d = '1;
      else if (act_q != '0) act_d = act_q - 1'b1;
      // flush wins over any handshake on the same edge
      if (clear_i) begin
         wp_d    = '0;
         rp_d    = '0;
         level_d = '0;
      end else begin
         if (push) wp_d = wp_q + 1'b1;
         if (pop)  rp_d = rp_q + 1'b1;
         if (push && !pop) level_d = level_q + 1'b1;
         if (pop && !push) level_d = level_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wp_q    <= '0;
         rp_q    <= '0;
         level_q <= '0;
         rx_q    <= '0;
         act_q   <= '0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         level_q <= level_d;
         rx_q    <= rx_d;
         act_q   <= act_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wp_q] <= bus.out_data_i;
   end
endmodule

// File: tb/tb_loopback_fifo.sv
// Directed bench for loopback_fifo: streaming, full/empty, clear, activity,
// counter wrap and asynchronous reset.
`timescale 1ns/1ps
module tb_loopback_fifo;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        clear = 1'b0;
   logic [6:0]  level;
   logic [15:0] rx_count;
   logic        activity;
   int          n_vec = 0;
   int          n_bad = 0;
   logic [15:0] exp_rx = 16'd0;

   loopback_fifo_if bus ();

   loopback_fifo #(.DEPTH(64), .ACT_BITS(4)) dut (
      .clk_i      (clk),
      .rstn_i     (rstn),
      .clear_i    (clear),
      .bus        (bus),
      .level_o    (level),
      .rx_count_o (rx_count),
      .activity_o (activity)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      bus.out_data_i  = 8'h00;
      bus.out_valid_i = 1'b0;
      bus.in_ready_i  = 1'b0;
      rstn = 1'b0;
      step();
      step();
      n_vec++;
      if (level !== 7'd0) begin
         n_bad++; $display("FAIL reset_level got %0d want 0", level);
      end
      n_vec++;
      if (bus.out_ready_o !== 1'b1 || bus.in_valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_hs got rdy=%b vld=%b want 1 0",
                  bus.out_ready_o, bus.in_valid_o);
      end
      n_vec++;
      if (rx_count !== 16'd0 || activity !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_cnt got rx=%0d act=%b want 0 0",
                  rx_count, activity);
      end
      rstn = 1'b1;
      step();
   endtask

   task automatic test_stream();
      for (int i = 0; i < 10; i++) begin
         bus.out_valid_i = 1'b1;
         bus.out_data_i  = 8'(i);
         step();
         exp_rx++;
      end
      bus.out_valid_i = 1'b0;
      n_vec++;
      if (level !== 7'd10 || bus.in_data_o !== 8'h00 || rx_count !== exp_rx) begin
         n_bad++;
         $display("FAIL stream_fill got lvl=%0d d=%h rx=%0d want 10 00 %0d",
                  level, bus.in_data_o, rx_count, exp_rx);
      end
      bus.in_ready_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         n_vec++;
         if (bus.in_valid_o !== 1'b1 || bus.in_data_o !== 8'(i)) begin
            n_bad++;
            $display("FAIL stream_drain got v=%b d=%h want 1 %h",
                     bus.in_valid_o, bus.in_data_o, 8'(i));
         end
         step();
      end
      bus.in_ready_i = 1'b0;
      n_vec++;
      if (level !== 7'd0 || bus.in_valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL stream_empty got lvl=%0d v=%b want 0 0",
                  level, bus.in_valid_o);
      end
   endtask

   task automatic test_full();
      for (int i = 0; i < 64; i++) begin
         bus.out_valid_i = 1'b1;
         bus.out_data_i  = 8'(i + 100);
         step();
         exp_rx++;
      end
      bus.out_data_i = 8'hEE;
      n_vec++;
      if (bus.out_ready_o !== 1'b0 || level !== 7'd64) begin
         n_bad++;
         $display("FAIL full_flag got rdy=%b lvl=%0d want 0 64",
                  bus.out_ready_o, level);
      end
      step();
      n_vec++;
      if (level !== 7'd64 || rx_count !== exp_rx) begin
         n_bad++;
         $display("FAIL full_hold got lvl=%0d rx=%0d want 64 %0d",
                  level, rx_count, exp_rx);
      end
      bus.in_ready_i = 1'b1;
      step();
      bus.in_ready_i = 1'b0;
      n_vec++;
      if (level !== 7'd63 || bus.out_ready_o !== 1'b1) begin
         n_bad++;
         $display("FAIL full_pop got lvl=%0d rdy=%b want 63 1",
                  level, bus.out_ready_o);
      end
      step();
      exp_rx++;
      bus.out_valid_i = 1'b0;
      n_vec++;
      if (level !== 7'd64 || rx_count !== exp_rx) begin
         n_bad++;
         $display("FAIL full_65th got lvl=%0d rx=%0d want 64 %0d",
                  level, rx_count, exp_rx);
      end
      bus.in_ready_i = 1'b1;
      for (int i = 1; i <= 64; i++) begin
         logic [7:0] e;
         e = (i == 64) ? 8'hEE : 8'(i + 100);
         n_vec++;
         if (bus.in_valid_o !== 1'b1 || bus.in_data_o !== e) begin
            n_bad++;
            $display("FAIL full_order got v=%b d=%h want 1 %h",
                     bus.in_valid_o, bus.in_data_o, e);
         end
         step();
      end
      bus.in_ready_i = 1'b0;
      n_vec++;
      if (level !== 7'd0) begin
         n_bad++; $display("FAIL full_drain got lvl=%0d want 0", level);
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 5; k++) begin
         bus.out_valid_i = 1'b1;
         bus.out_data_i  = 8'(k);
         step();
         exp_rx++;
      end
      bus.in_ready_i = 1'b1;
      for (int k = 5; k < 105; k++) begin
         bus.out_data_i = 8'(k);
         n_vec++;
         if (bus.in_data_o !== 8'(k - 5) || level !== 7'd5) begin
            n_bad++;
            $display("FAIL b2b_seq got d=%h lvl=%0d want %h 5",
                     bus.in_data_o, level, 8'(k - 5));
         end
         step();
         exp_rx++;
      end
      bus.out_valid_i = 1'b0;
      n_vec++;
      if (level !== 7'd5 || rx_count !== exp_rx) begin
         n_bad++;
         $display("FAIL b2b_end got lvl=%0d rx=%0d want 5 %0d",
                  level, rx_count, exp_rx);
      end
      for (int k = 100; k < 105; k++) begin
         n_vec++;
         if (bus.in_data_o !== 8'(k)) begin
            n_bad++;
            $display("FAIL b2b_tail got d=%h want %h", bus.in_data_o, 8'(k));
         end
         step();
      end
      bus.in_ready_i = 1'b0;
   endtask

   task automatic test_clear();
      for (int k = 0; k < 7; k++) begin
         bus.out_valid_i = 1'b1;
         bus.out_data_i  = 8'(k + 50);
         step();
         exp_rx++;
      end
      n_vec++;
      if (level !== 7'd7) begin
         n_bad++; $display("FAIL clr_pre got lvl=%0d want 7", level);
      end
      clear = 1'b1;
      bus.in_ready_i = 1'b1;
      bus.out_data_i = 8'h77;
      step();
      exp_rx++;
      clear = 1'b0;
      bus.in_ready_i  = 1'b0;
      bus.out_valid_i = 1'b0;
      n_vec++;
      if (level !== 7'd0 || bus.in_valid_o !== 1'b0 || rx_count !== exp_rx) begin
         n_bad++;
         $display("FAIL clr_post got lvl=%0d v=%b rx=%0d want 0 0 %0d",
                  level, bus.in_valid_o, rx_count, exp_rx);
      end
   endtask

   task automatic test_activity();
      repeat (20) step();
      n_vec++;
      if (activity !== 1'b0) begin
         n_bad++; $display("FAIL act_idle got %b want 0", activity);
      end
      bus.out_valid_i = 1'b1;
      bus.out_data_i  = 8'h5A;
      step();
      exp_rx++;
      bus.out_valid_i = 1'b0;
      for (int i = 0; i < 15; i++) begin
         n_vec++;
         if (activity !== 1'b1) begin
            n_bad++;
            $display("FAIL act_high cyc=%0d got %b want 1", i, activity);
         end
         step();
      end
      n_vec++;
      if (activity !== 1'b0) begin
         n_bad++; $display("FAIL act_fall got %b want 0", activity);
      end
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 19; k++) begin
         bus.out_valid_i = 1'b1;
         bus.out_data_i  = 8'(k);
         step();
      end
      bus.out_valid_i = 1'b0;
      n_vec++;
      if (level !== 7'd20) begin
         n_bad++; $display("FAIL arst_pre got lvl=%0d want 20", level);
      end
      #2 rstn = 1'b0;
      #1;
      n_vec++;
      if (level !== 7'd0 || bus.out_ready_o !== 1'b1 || bus.in_valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL arst_now got lvl=%0d rdy=%b v=%b want 0 1 0",
                  level, bus.out_ready_o, bus.in_valid_o);
      end
      n_vec++;
      if (rx_count !== 16'd0 || activity !== 1'b0) begin
         n_bad++;
         $display("FAIL arst_cnt got rx=%0d act=%b want 0 0", rx_count, activity);
      end
      @(negedge clk);
      rstn = 1'b1;
      step();
      n_vec++;
      if (level !== 7'd0 || bus.out_ready_o !== 1'b1) begin
         n_bad++;
         $display("FAIL arst_rel got lvl=%0d rdy=%b want 0 1",
                  level, bus.out_ready_o);
      end
   endtask

   task automatic test_wrap();
      bus.out_valid_i = 1'b1;
      bus.in_ready_i  = 1'b1;
      for (int k = 0; k < 65537; k++) begin
         bus.out_data_i = 8'(k);
         step();
      end
      bus.out_valid_i = 1'b0;
      bus.in_ready_i  = 1'b0;
      n_vec++;
      if (rx_count !== 16'h0001 || level !== 7'd1 || bus.in_data_o !== 8'h00) begin
         n_bad++;
         $display("FAIL wrap got rx=%h lvl=%0d d=%h want 0001 1 00",
                  rx_count, level, bus.in_data_o);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_full();
      test_back_to_back();
      test_clear();
      test_activity();
      test_async_reset();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
